// File: rtl/iterative_alu.sv
// Registered RV32I ALU (1-cycle latency) with an optional iterative RV32M mul/div unit.
// Define ITERATIVE_ALU_MULDIV_EN to build the mul/div path; otherwise codes 16-23 return 0.
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] base_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        shamt    = operand_2[SHW-1:0];
        base_res = '0;
        case (operation)
            5'd0:    base_res = operand_1 + operand_2;
            5'd1:    base_res = operand_1 - operand_2;
            5'd2:    base_res = operand_1 & operand_2;
            5'd3:    base_res = operand_1 | operand_2;
            5'd4:    base_res = operand_1 ^ operand_2;
            5'd5:    base_res = operand_1 << shamt;
            5'd6:    base_res = operand_1 >> shamt;
            5'd7:    base_res = $signed(operand_1) >>> shamt;
            5'd8:    base_res = {{(WIDTH-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
            5'd9:    base_res = {{(WIDTH-1){1'b0}}, (operand_1 < operand_2)};
            default: base_res = '0;
        endcase
    end

`ifdef ITERATIVE_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, prod;
    logic [WIDTH-1:0]     mq_q, mq_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]     a_mag, b_mag, quo, rem;
    logic [WIDTH:0]       sum, trial;
    logic [SHW:0]         cnt_q, cnt_d;
    logic [4:0]           op_q, op_d;
    logic                 neg_q, neg_d, rneg_q, rneg_d;
    logic                 is_md, a_neg, b_neg;

    // mq holds the multiplier (shifted out LSB first) or the dividend/quotient
    // (shifted MSB out, quotient bit in); dvs holds multiplicand or divisor.
    always_comb begin
        is_md = (operation[4:3] == 2'b10);
        a_neg = operand_1[WIDTH-1] & (operation inside {5'd17, 5'd18, 5'd20, 5'd22});
        b_neg = operand_2[WIDTH-1] & (operation inside {5'd17, 5'd20, 5'd22});
        a_mag = a_neg ? -operand_1 : operand_1;
        b_mag = b_neg ? -operand_2 : operand_2;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mq_q[0] ? {1'b0, dvs_q} : '0);
        trial = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]} - {1'b0, dvs_q};
        prod  = neg_q ? -acc_q : acc_q;
        quo   = neg_q ? -mq_q : mq_q;
        rem   = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

        state_d  = state_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: if (start) begin
                if (is_md) begin
                    acc_d   = '0;
                    mq_d    = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = CNT_INIT;
                    op_d    = operation;
                    // Divide by zero keeps the all-ones quotient unsigned-looking.
                    neg_d   = (a_neg ^ b_neg) & (~operation[2] | (operand_2 != '0));
                    rneg_d  = a_neg;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    result_d = base_res;
                    done_d   = 1'b1;
                end
            end
            RUN: begin
                if (op_q[2]) begin
                    if (!trial[WIDTH]) acc_d = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
                    else               acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
                    mq_d = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                    mq_d  = mq_q >> 1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) state_d = FINISH;
            end
            FINISH: begin
                case (op_q[2:0])
                    3'd0:             result_d = prod[WIDTH-1:0];
                    3'd1, 3'd2, 3'd3: result_d = prod[2*WIDTH-1:WIDTH];
                    3'd4, 3'd5:       result_d = quo;
                    default:          result_d = rem;
                endcase
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end
`else
    always_comb begin
        result_d = start ? base_res : result_q;
        done_d   = start;
        busy_d   = 1'b0;
    end
`endif

    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: cycle-level reference model plus directed vectors with literal expectations.
module tb_iterative_alu;
    localparam int W = 32;
`ifdef ITERATIVE_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4:0]   operation = '0;
    logic [W-1:0] operand_1 = '0, operand_2 = '0;
    logic [W-1:0] result;
    logic         zero, busy, done;

    int n_cmp = 0, n_err = 0;
    bit cmp_en = 1'b0;

    iterative_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2),
        .result(result), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit is_md(input logic [4:0] op);
        return MD && (op >= 5'd16) && (op <= 5'd23);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        if (is_md(op)) begin
            case (op)
                5'd16: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
                5'd17: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
                5'd18: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
                5'd19: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
                5'd20: begin
                    if (b == 0) return 32'hFFFFFFFF;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                    return sa / sb;
                end
                5'd21: return (b == 0) ? 32'hFFFFFFFF : a / b;
                5'd22: begin
                    if (b == 0) return a;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                    return sa % sb;
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << b[4:0];
            5'd6:    return a >> b[4:0];
            5'd7:    return $signed(a) >>> b[4:0];
            5'd8:    return {31'b0, ($signed(a) < $signed(b))};
            5'd9:    return {31'b0, (a < b)};
            default: return 32'h0;
        endcase
    endfunction

    // Reference: an accepted mul/div op completes WIDTH+1 edges after the start edge.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_res, m_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end else if (start) begin
                if (is_md(operation)) begin
                    m_pend <= ref_alu(operation, operand_1, operand_2);
                    m_left <= W + 1;
                end else begin
                    m_done <= 1'b1;
                    m_res  <= ref_alu(operation, operand_1, operand_2);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if (done !== m_done || busy !== (m_left > 0) || result !== m_res || zero !== (m_res == '0)) begin
                n_err++;
                $display("FAIL cycle-check t=%0t: done=%b busy=%b result=%h zero=%b, want done=%b busy=%b result=%h zero=%b",
                         $time, done, busy, result, zero, m_done, (m_left > 0), m_res, (m_res == '0));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit now);
        int lat, nb;
        if (!now) begin @(posedge clk); #2; end
        start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
        @(posedge clk); #2;
        start = 1'b0; operand_1 = $urandom; operand_2 = $urandom;
        lat = 0; nb = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin lat = k; break; end
        end
        chk({name, " result"}, result, exp);
        chk({name, " latency"}, lat, is_md(op) ? 34 : 1);
        chk({name, " busy cycles"}, nb, is_md(op) ? 33 : 0);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk({name, " done seen"}, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 cmp_en = 1'b1;
        @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset zero", {31'b0, zero}, 32'd1);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        run("ADD 5+7", 5'd0, 32'd5, 32'd7, 32'd12, 1'b0);
        chk("ADD zero", {31'b0, zero}, 32'd0);
        run("SUB 3-3", 5'd1, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("SUB zero", {31'b0, zero}, 32'd1);
        run("SRA", 5'd7, 32'h80000000, 32'h24, 32'hF8000000, 1'b0);
        run("SRL", 5'd6, 32'h80000000, 32'h24, 32'h08000000, 1'b0);
        run("SLL", 5'd5, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0);
        run("SLTU", 5'd9, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
        run("SLT", 5'd8, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run("AND", 5'd2, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
        run("OR", 5'd3, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1'b0);
        run("XOR", 5'd4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0);
        run("undef 10", 5'd10, 32'd9, 32'd9, 32'd0, 1'b0);

`ifdef ITERATIVE_ALU_MULDIV_EN
        run("MULH -1*-1", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run("MULHU", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run("MULHSU -1*2", 5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0);
        run("DIV 7/0", 5'd20, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0);
        run("DIV -7/0", 5'd20, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b0);
        run("REMU 7/0", 5'd23, 32'd7, 32'd0, 32'd7, 1'b0);
        run("DIV ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run("REM ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);
        run("DIV -7/2", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run("REM -7/2", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run("DIVU 100/7", 5'd21, 32'd100, 32'd7, 32'd14, 1'b0);
        run("REMU 100/7", 5'd23, 32'd100, 32'd7, 32'd2, 1'b0);

        // An ADD offered mid-RUN must be dropped.
        @(posedge clk); #2;
        start = 1'b1; operation = 5'd16; operand_1 = 32'd6; operand_2 = 32'd7;
        @(posedge clk); #2 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 start = 1'b1; operation = 5'd0; operand_1 = 32'd1; operand_2 = 32'd1;
        @(posedge clk); #2 start = 1'b0;
        wait_done("MUL with ignored ADD");
        chk("MUL with ignored ADD result", result, 32'd42);

        // Abort at iteration 10.
        @(posedge clk); #2;
        start = 1'b1; operation = 5'd21; operand_1 = 32'd100; operand_2 = 32'd7;
        @(posedge clk); #2 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort result", result, 32'h0);
        chk("abort zero", {31'b0, zero}, 32'd1);
        chk("abort busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("abort no done", ndone, 32'd0);
        run("MUL 6*7", 5'd16, 32'd6, 32'd7, 32'd42, 1'b0);

        run("MUL 3*5", 5'd16, 32'd3, 32'd5, 32'd15, 1'b0);
        run("b2b ADD", 5'd0, 32'd2, 32'd2, 32'd4, 1'b1);
`else
        run("MUL disabled", 5'd16, 32'd6, 32'd7, 32'd0, 1'b0);
        run("DIV disabled", 5'd20, 32'd7, 32'd0, 32'd0, 1'b0);
        run("b2b ADD", 5'd0, 32'd2, 32'd2, 32'd4, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
